// File: rtl/cpa_pkg.sv
// Shared definitions for the carry-save accumulator and the CPA stage downstream of it.
package cpa_pkg;

    localparam int CPA_MAX_BITS = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } csa_acc_state_t;

    function automatic int acc_w(input int width, input int guard);
        return width + guard;
    endfunction

endpackage

// File: rtl/csa_3to2_row.sv
// One row of independent full adders: three N-bit vectors in, bitwise sum and carry-out out.
module csa_3to2_row #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] cout
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign cout[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
        end
    endgenerate

endmodule

// File: rtl/csa_accumulator.sv
// Streaming carry-save accumulator: sums a burst one operand per cycle and presents the
// redundant (sum, carry) pair for a downstream carry-propagate adder.
module csa_accumulator
    import cpa_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int GUARD = 4,
    localparam int ACC_W = acc_w(WIDTH, GUARD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [ACC_W-1:0] out_carry,
    output logic [GUARD:0]   out_beats,
    output logic             out_ovf
);

    generate
        if (ACC_W > CPA_MAX_BITS) begin : g_acc_w_check
            $error("csa_accumulator: ACC_W exceeds CPA_MAX_BITS");
        end
    endgenerate

    localparam logic [GUARD+1:0] CNT_ONE   = (GUARD + 2)'(1);
    localparam logic [GUARD+1:0] OVF_LIMIT = CNT_ONE << GUARD;

    csa_acc_state_t   state_reg, state_next;
    logic [ACC_W-1:0] s_reg, c_reg;
    logic [GUARD:0]   cnt_reg;
    logic [ACC_W-1:0] out_sum_reg, out_carry_reg;
    logic [GUARD:0]   out_beats_reg;
    logic             out_ovf_reg;

    logic             accept;
    logic             first_beat;
    logic [ACC_W-1:0] row_a, row_b, row_c;
    logic [ACC_W-1:0] row_sum, row_cout;
    logic [ACC_W-1:0] carry_shifted;
    logic             unused_carry_msb;
    logic [GUARD+1:0] cnt_unsat;
    logic [GUARD:0]   cnt_sat;
    logic             ovf_new;

    // in_ready looks only at state and out_ready, so there is no in_valid->in_ready loop.
    assign in_ready   = (state_reg != HOLD) || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_beat = (state_reg != ACCUM);

    // A first beat compresses against zero, which yields S = x, C = 0.
    assign row_a = first_beat ? '0 : s_reg;
    assign row_b = first_beat ? '0 : c_reg;
    assign row_c = ACC_W'(in_data);

    csa_3to2_row #(
        .N(ACC_W)
    ) u_row (
        .a   (row_a),
        .b   (row_b),
        .c   (row_c),
        .sum (row_sum),
        .cout(row_cout)
    );

    assign carry_shifted    = {row_cout[ACC_W-2:0], 1'b0};
    assign unused_carry_msb = row_cout[ACC_W-1];

    assign cnt_unsat = first_beat ? CNT_ONE : ({1'b0, cnt_reg} + CNT_ONE);
    assign cnt_sat   = cnt_unsat[GUARD+1] ? '1 : cnt_unsat[GUARD:0];
    assign ovf_new   = (cnt_unsat > OVF_LIMIT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) state_next = in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                if (accept)         state_next = in_last ? HOLD : ACCUM;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            c_reg         <= '0;
            cnt_reg       <= '0;
            out_sum_reg   <= '0;
            out_carry_reg <= '0;
            out_beats_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                s_reg   <= row_sum;
                c_reg   <= carry_shifted;
                cnt_reg <= cnt_sat;
                if (in_last) begin
                    out_sum_reg   <= row_sum;
                    out_carry_reg <= carry_shifted;
                    out_beats_reg <= cnt_sat;
                    out_ovf_reg   <= ovf_new;
                end
            end
        end
    end

    assign out_valid = (state_reg == HOLD);
    assign out_sum   = out_sum_reg;
    assign out_carry = out_carry_reg;
    assign out_beats = out_beats_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator (WIDTH=8, GUARD=4) with a reference CPA model.
module tb_csa_accumulator;

    localparam int WIDTH = 8;
    localparam int GUARD = 4;
    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [ACC_W-1:0] out_carry;
    logic [GUARD:0]   out_beats;
    logic             out_ovf;

    int errors = 0;
    int checks = 0;

    csa_accumulator #(
        .WIDTH(WIDTH),
        .GUARD(GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_beats(out_beats),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] cpa(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        return a + b;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one beat, let one rising edge pass, then sample 1 time unit later.
    task automatic send(input logic [WIDTH-1:0] x, input logic last);
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic report(input string tag);
        $display("%s: valid=%0d sum=0x%03h carry=0x%03h total=0x%03h beats=%0d ovf=%0d",
                 tag, out_valid, out_sum, out_carry, cpa(out_sum, out_carry), out_beats, out_ovf);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_beats", 32'(out_beats), 32'd0);
        check("rst_ovf",   32'(out_ovf),   32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);

        // 1: three beats of 0xFF
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        send(8'hFF, 1'b1);
        report("t1");
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_total", 32'(cpa(out_sum, out_carry)), 32'h2FD);
        check("t1_sum",   32'(out_sum),   32'h101);
        check("t1_carry", 32'(out_carry), 32'h1FC);
        check("t1_beats", 32'(out_beats), 32'd3);
        check("t1_ovf",   32'(out_ovf),   32'd0);
        idle_cycle();
        check("t1_drain", 32'(out_valid), 32'd0);

        // 2: single-beat burst
        send(8'h5A, 1'b1);
        report("t2");
        check("t2_sum",   32'(out_sum),   32'h05A);
        check("t2_carry", 32'(out_carry), 32'h000);
        check("t2_total", 32'(cpa(out_sum, out_carry)), 32'h05A);
        check("t2_beats", 32'(out_beats), 32'd1);
        idle_cycle();

        // 3: seventeen then sixteen beats of 0xFF around the 2^GUARD boundary
        for (int i = 0; i < 17; i++) send(8'hFF, (i == 16));
        report("t3a");
        check("t3a_total", 32'(cpa(out_sum, out_carry)), 32'h0EF);
        check("t3a_beats", 32'(out_beats), 32'd17);
        check("t3a_ovf",   32'(out_ovf),   32'd1);
        idle_cycle();
        for (int i = 0; i < 16; i++) send(8'hFF, (i == 15));
        report("t3b");
        check("t3b_total", 32'(cpa(out_sum, out_carry)), 32'hFF0);
        check("t3b_beats", 32'(out_beats), 32'd16);
        check("t3b_ovf",   32'(out_ovf),   32'd0);
        idle_cycle();

        // 4: backpressure while a new beat waits, then drain and accept in the same cycle
        out_ready = 1'b0;
        send(8'hAA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h33;
            in_last  = 1'b0;
            #1;
            check("t4_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_sum",   32'(out_sum),   32'h0AA);
            check("t4_hold_beats", 32'(out_beats), 32'd1);
        end
        out_ready = 1'b1;
        in_data   = 8'h01;
        in_last   = 1'b1;
        #1;
        check("t4_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        report("t4");
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_total", 32'(cpa(out_sum, out_carry)), 32'h001);
        check("t4_beats", 32'(out_beats), 32'd1);
        idle_cycle();

        // 5: back-to-back bursts with no input bubble
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        report("t5a");
        check("t5a_total", 32'(cpa(out_sum, out_carry)), 32'h030);
        check("t5a_beats", 32'(out_beats), 32'd2);
        check("t5_ready",  32'(in_ready),  32'd1);
        send(8'h03, 1'b1);
        report("t5b");
        check("t5b_valid", 32'(out_valid), 32'd1);
        check("t5b_total", 32'(cpa(out_sum, out_carry)), 32'h003);
        check("t5b_beats", 32'(out_beats), 32'd1);
        idle_cycle();

        // 6: reset mid-burst discards partial state
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_beats", 32'(out_beats), 32'd0);
        check("t6_ready", 32'(in_ready),  32'd1);
        send(8'h07, 1'b1);
        report("t6");
        check("t6_sum",   32'(out_sum),   32'h007);
        check("t6_carry", 32'(out_carry), 32'h000);
        check("t6_total", 32'(cpa(out_sum, out_carry)), 32'h007);
        check("t6_nbeats", 32'(out_beats), 32'd1);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

- Streaming carry-save accumulator that sits directly upstream of the parallel-prefix carry-propagate adder in the CPA stage.
- Sums a burst of unsigned operands at one operand per cycle, using one 3:2 compressor row and no carry propagation.
- Emits the redundant (sum, carry) pair, whose arithmetic total is the burst sum modulo 2^ACC_W.
- The pair feeds the CPA's `a`/`b` inputs with `ci=0`; the CPA's `s` output is the final result.

## Interface
- `WIDTH`, 8 — input operand width (1..120).
- `GUARD`, 4 — guard bits; ACC_W = WIDTH+GUARD (≤128, within CPA support).
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — operand beat valid.
- `in_ready` output 1 — block accepts a beat this cycle.
- `in_data` input WIDTH — unsigned operand, zero-extended to ACC_W.
- `in_last` input 1 — beat closes the burst.
- `out_valid` output 1 — result pair valid.
- `out_ready` input 1 — downstream consumes the pair.
- `out_sum` output ACC_W — CSA sum vector (CPA `a`).
- `out_carry` output ACC_W — CSA carry vector (CPA `b`).
- `out_beats` output GUARD+1 — beats in the burst, saturating at 2^(GUARD+1)-1.
- `out_ovf` output 1 — burst exceeded 2^GUARD beats, so the result may have wrapped.

## Operation
- States:
  - IDLE: no burst open.
  - ACCUM: burst open.
  - HOLD: result presented.
- Beat accepted when `in_valid && in_ready`.
- `in_ready` = (state != HOLD) || `out_ready`. Handshake is skid-free, with no combinational path from `in_valid` to `in_ready`.
- First beat (accepted in IDLE, or in HOLD while the result drains): S ← x, C ← 0, cnt ← 1.
- Subsequent beats (ACCUM):
  - S ← S ^ C ^ x.
  - C ← (maj(S,C,x) << 1) truncated to ACC_W.
  - cnt ← sat(cnt+1).
- Invariant: (S + C) mod 2^ACC_W = Σ beats mod 2^ACC_W.
- Accepted beat with `in_last=1`: the updated S/C/cnt load the output registers and state → HOLD.
- Accepted beat with `in_last=0`: state → ACCUM.
- A single beat with `in_last=1` in IDLE is a legal burst: out_sum=x, out_carry=0, out_beats=1.
- `out_ovf` = (beat count > 2^GUARD). It is computed from the unsaturated comparison and stays asserted once the counter saturates.
- HOLD with `out_ready=1`:
  - No beat accepted: state → IDLE.
  - First beat accepted in the same cycle: state → ACCUM, or stays HOLD with the new result if that beat also has `in_last`.
- `in_data`/`in_last` are ignored when `in_valid=0`.
- Reset mid-burst or mid-HOLD discards all partial and held data with no output.
- Reset values:
  - `out_valid=0`, `out_sum=0`, `out_carry=0`, `out_beats=0`, `out_ovf=0`.
  - State IDLE; S=C=0, cnt=0.

## Timing
- Throughput: one beat per cycle, sustained, including back-to-back bursts while `out_ready=1`.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Outputs are registered. `out_sum`, `out_carry`, `out_beats`, `out_ovf` stay stable while `out_valid && !out_ready`.
- Critical path is one full-adder row plus a mux, independent of WIDTH. All carry propagation is deferred to the CPA stage.
- `in_ready` depends only on state and `out_ready`. The combinational `out_ready`→`in_ready` path is intentional and documented.
- `rst` dominates all other inputs in the same cycle.

## Structure
- Shared package `cpa_pkg`:
  - State enum `csa_acc_state_t {IDLE, ACCUM, HOLD}`.
  - Function `acc_w(WIDTH, GUARD)`.
  - Constant `CPA_MAX_BITS = 128` for elaboration checks.
- One sub-module: `csa_3to2_row #(N)`, a combinational bitwise full-adder row producing (sum, carry-out vector). Its carry is shifted and truncated in the parent.
- Elaboration assertion: ACC_W ≤ CPA_MAX_BITS.

## Test plan
All cases use WIDTH=8, GUARD=4, ACC_W=12. Every check verifies (out_sum+out_carry) mod 4096 through a reference CPA model.

1. Beats 0xFF, 0xFF, 0xFF(last) on consecutive cycles → `out_valid` one cycle after the last beat; total 0x2FD; out_beats=3; out_ovf=0.
2. Single beat 0x5A with last → out_sum=0x05A, out_carry=0x000, out_beats=1.
3. Seventeen beats of 0xFF → total 0x0EF (4335 mod 4096); out_beats=17; out_ovf=1. With sixteen beats → total 0xFF0; out_ovf=0.
4. Hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, outputs stable. Then assert `out_ready=1` with beat 0x01(last) → same cycle accepted; next cycle a new result with total 0x001.
5. Back-to-back bursts {0x10, 0x20(last)}, {0x03(last)} with `out_ready` tied 1 → results 0x030 then 0x003, with no bubble on input.
6. Assert `rst` after 2 beats of a burst → next cycle `out_valid=0`, in IDLE. The next burst 0x07(last) yields 0x007, beats=1.
